console_ctrl: RTL and testbench

- Memory-mapped console output controller on the core's data-memory bus.
- Captures byte stores to the console address (0xFFFC) into a FIFO and drains them to a character sink over a valid/ready handshake.
- Back-pressures the core with a stall when the FIFO is full.
- Exposes a status/control register so software can poll fill level, flush the FIFO and read a sent-character count.

---
 rtl/console_ctrl.sv | 98 +++++++++
 tb/tb_console_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_ctrl.sv
// rtl/console_ctrl.sv - memory-mapped console output FIFO with status/control register
// Byte stores to CONSOLE_ADDR are queued and drained to a valid/ready character sink.
module console_ctrl #(
  parameter logic [31:0] CONSOLE_ADDR = 32'h0000FFFC,
  parameter logic [31:0] STATUS_ADDR  = 32'h0000FFF8,
  parameter int unsigned DEPTH        = 8,
  parameter bit          DROP_ON_FULL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        rd_hit,
  output logic        stall,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   sent_q, sent_d;
  logic          overflow_q, overflow_d;

  logic wr_hit, ctl_hit, full, empty, push, pop, drop;
  logic flush, clr_sent, clr_ovf;
  logic unused_wdata;

  assign wr_hit   = memwrite && (dataadr == CONSOLE_ADDR);
  assign ctl_hit  = memwrite && (dataadr == STATUS_ADDR);
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = wr_hit && !full;
  assign pop      = !empty && char_ready;
  assign drop     = DROP_ON_FULL && wr_hit && full;
  assign flush    = ctl_hit && writedata[0];
  assign clr_sent = ctl_hit && writedata[1];
  assign clr_ovf  = ctl_hit && writedata[2];
  assign unused_wdata = ^writedata[31:8];

  // Stall deliberately ignores char_ready: a freed slot is used one cycle later.
  assign stall      = !DROP_ON_FULL && wr_hit && full && reset;
  assign rd_hit     = memread && (dataadr == STATUS_ADDR) && reset;
  assign readdata   = rd_hit ? {sent_q, 8'(count_q), 5'b0, overflow_q, full, empty} : 32'h0;
  assign char_valid = !empty;
  assign char_data  = mem_q[rd_ptr_q];
  assign overflow   = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sent_d     = sent_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    // A byte accepted by the sink counts as sent even if flushed in the same cycle.
    if (clr_sent)  sent_d = '0;
    else if (pop)  sent_d = sent_q + 16'd1;
    if (clr_ovf)   overflow_d = 1'b0;
    else if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sent_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sent_q     <= sent_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= writedata[7:0];
  end
endmodule

// File: tb/tb_console_ctrl.sv
// tb/tb_console_ctrl.sv - randomized and directed bench for console_ctrl against a queue model
// Two instances (stalling and dropping) share one bus; each has its own reference queue.
module tb_console_ctrl;
  localparam logic [31:0] CON   = 32'h0000FFFC;
  localparam logic [31:0] STA   = 32'h0000FFF8;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic        char_ready = 1'b0;
  logic [31:0] dataadr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata [2];
  logic        rd_hit [2];
  logic        stall [2];
  logic        char_valid [2];
  logic [7:0]  char_data [2];
  logic        overflow [2];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];
  logic [15:0] msent [2];
  logic        movf [2];
  logic [7:0]  got [$];
  logic [7:0]  sentb [$];

  console_ctrl #(.DEPTH(DEPTH), .DROP_ON_FULL(1'b0)) u_stall (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .dataadr(dataadr), .writedata(writedata), .readdata(readdata[0]),
    .rd_hit(rd_hit[0]), .stall(stall[0]), .char_valid(char_valid[0]),
    .char_data(char_data[0]), .char_ready(char_ready), .overflow(overflow[0])
  );

  console_ctrl #(.DEPTH(DEPTH), .DROP_ON_FULL(1'b1)) u_drop (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .dataadr(dataadr), .writedata(writedata), .readdata(readdata[1]),
    .rd_hit(rd_hit[1]), .stall(stall[1]), .char_valid(char_valid[1]),
    .char_data(char_data[1]), .char_ready(char_ready), .overflow(overflow[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_word(input int sz, input logic [15:0] s, input logic o);
    return {s, 8'(sz), 5'b0, o, sz == DEPTH, sz == 0};
  endfunction

  // Reference: each FIFO is a plain queue; the edge applies pop, then flush or push.
  task automatic model_step();
    logic wr, ctl, full0, full1, pop0, pop1;
    wr    = memwrite && dataadr == CON;
    ctl   = memwrite && dataadr == STA;
    full0 = q0.size() == DEPTH;
    full1 = q1.size() == DEPTH;
    pop0  = q0.size() != 0 && char_ready;
    pop1  = q1.size() != 0 && char_ready;
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (ctl && writedata[0]) begin
      q0.delete();
      q1.delete();
    end else begin
      if (wr && !full0) q0.push_back(writedata[7:0]);
      if (wr && !full1) q1.push_back(writedata[7:0]);
    end
    if (ctl && writedata[1]) begin
      msent[0] = 16'h0;
      msent[1] = 16'h0;
    end else begin
      if (pop0) msent[0] = msent[0] + 16'd1;
      if (pop1) msent[1] = msent[1] + 16'd1;
    end
    if (ctl && writedata[2]) movf[1] = 1'b0;
    else if (wr && full1)    movf[1] = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      q0.delete();
      q1.delete();
      msent[0] = 16'h0;
      msent[1] = 16'h0;
      movf[0]  = 1'b0;
      movf[1]  = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic cmp_inst(input int k, input int sz, input logic [7:0] head, input bit drop);
    logic hit, wr;
    hit = reset && memread && dataadr == STA;
    wr  = memwrite && dataadr == CON;
    chk($sformatf("u%0d.rd_hit", k), 32'(rd_hit[k]), 32'(hit));
    chk($sformatf("u%0d.readdata", k), readdata[k], hit ? status_word(sz, msent[k], movf[k]) : 32'h0);
    chk($sformatf("u%0d.char_valid", k), 32'(char_valid[k]), 32'(reset && sz != 0));
    if (sz != 0) chk($sformatf("u%0d.char_data", k), 32'(char_data[k]), 32'(head));
    chk($sformatf("u%0d.stall", k), 32'(stall[k]), 32'(!drop && reset && wr && sz == DEPTH));
    chk($sformatf("u%0d.overflow", k), 32'(overflow[k]), 32'(movf[k]));
  endtask

  initial forever begin
    @(negedge clk);
    cmp_inst(0, q0.size(), q0.size() != 0 ? q0[0] : 8'h0, 1'b0);
    cmp_inst(1, q1.size(), q1.size() != 0 ? q1[0] : 8'h0, 1'b1);
    if (reset && char_valid[0] && char_ready) got.push_back(char_data[0]);
  end

  // Store helper: entered and left at posedge+1; holds the bus while the stalling copy stalls.
  task automatic store(input logic [31:0] adr, input logic [31:0] wd);
    int guard;
    guard = 0;
    memwrite = 1'b1;
    dataadr = adr;
    writedata = wd;
    @(negedge clk);
    while (stall[0] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("store_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    memwrite = 1'b0;
    dataadr = 32'h0;
    writedata = 32'h0;
  endtask

  task automatic read_status(output logic [31:0] r0, output logic [31:0] r1);
    memread = 1'b1;
    dataadr = STA;
    @(negedge clk);
    r0 = readdata[0];
    r1 = readdata[1];
    @(posedge clk); #1;
    memread = 1'b0;
    dataadr = 32'h0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    char_ready = 1'b1;
    while ((char_valid[0] || char_valid[1]) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk(name, 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0, r1;
    logic        st;
    int          idx, guard;
    logic [7:0]  b;

    memread = 1'b1; memwrite = 1'b1; dataadr = STA; writedata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst.char_valid", 32'(char_valid[0]), 32'd0);
    chk("rst.stall", 32'(stall[0]), 32'd0);
    chk("rst.rd_hit", 32'(rd_hit[0]), 32'd0);
    chk("rst.readdata", readdata[0], 32'h0);
    chk("rst.overflow", 32'(overflow[1]), 32'd0);
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0; dataadr = 32'h0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single byte: visible exactly one cycle after the store, popped, counted.
    char_ready = 1'b1;
    store(CON, 32'h00000041);
    chk("t1.char_valid", 32'(char_valid[0]), 32'd1);
    chk("t1.char_data", 32'(char_data[0]), 32'h41);
    @(posedge clk); #1;
    read_status(r0, r1);
    chk("t1.status", r0, 32'h00010001);
    chk("t1.status_drop", r1, 32'h00010001);
    store(STA, 32'h7);

    // Fill to full, hold a stalled ninth store, then release the sink.
    char_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 8; i++) store(CON, 32'(8'h41 + i));
    read_status(r0, r1);
    chk("t2.status_full", r0, 32'h00000802);
    chk("t2.status_full_drop", r1, 32'h00000802);
    memwrite = 1'b1; dataadr = CON; writedata = 32'h49;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2.stall_held", 32'(stall[0]), 32'd1);
      chk("t2.drop_no_stall", 32'(stall[1]), 32'd0);
      @(posedge clk); #1;
    end
    char_ready = 1'b1;
    guard = 0;
    @(negedge clk);
    while (stall[0] && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("t2.unstall", 32'(guard), 32'd1);
    @(posedge clk); #1;
    memwrite = 1'b0; dataadr = 32'h0;
    drain("t2.drain_timeout");
    char_ready = 1'b0;
    chk("t2.sink_count", 32'(got.size()), 32'd9);
    for (int i = 0; i < 9 && i < got.size(); i++)
      chk($sformatf("t2.sink[%0d]", i), 32'(got[i]), 32'(8'h41 + i));
    chk("t2.overflow", 32'(overflow[1]), 32'd1);
    read_status(r0, r1);
    chk("t2.status", r0, 32'h00090001);
    chk("t2.status_drop", r1, 32'h00090005);
    store(STA, 32'h4);
    chk("t2.ovf_clear", 32'(overflow[1]), 32'd0);

    // Flush racing a pop: flush wins, the accepted byte still counts.
    store(STA, 32'h7);
    for (int i = 0; i < 3; i++) store(CON, 32'(8'h61 + i));
    char_ready = 1'b1;
    memwrite = 1'b1; dataadr = STA; writedata = 32'h1;
    @(posedge clk); #1;
    memwrite = 1'b0; dataadr = 32'h0; writedata = 32'h0;
    char_ready = 1'b0;
    chk("t4.char_valid", 32'(char_valid[0]), 32'd0);
    read_status(r0, r1);
    chk("t4.status", r0, 32'h00010001);

    // Stream with a toggling sink: pointers wrap, order and count preserved.
    store(STA, 32'h7);
    got.delete();
    sentb.delete();
    idx = 0; guard = 0; st = 1'b0;
    while (guard < 600) begin
      char_ready = ~char_ready;
      if (!(memwrite && st)) begin
        if (idx < 20) begin
          b = 8'($urandom);
          sentb.push_back(b);
          memwrite = 1'b1; dataadr = CON; writedata = {24'h0, b};
          idx++;
        end else begin
          memwrite = 1'b0; dataadr = 32'h0;
        end
      end
      if (idx == 20 && !memwrite && !char_valid[0]) break;
      @(negedge clk); st = stall[0];
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 600) chk("t5.timeout", 32'd1, 32'd0);
    char_ready = 1'b0;
    chk("t5.sink_count", 32'(got.size()), 32'd20);
    for (int i = 0; i < 20 && i < got.size(); i++)
      chk($sformatf("t5.sink[%0d]", i), 32'(got[i]), 32'(sentb[i]));
    read_status(r0, r1);
    chk("t5.status", r0, 32'h00140001);

    // Randomized bus traffic; stores are held while stalled.
    st = 1'b0;
    for (int c = 0; c < 600; c++) begin
      char_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (!(memwrite && st)) begin
        case ($urandom_range(0, 11))
          0, 1, 2, 3, 4: begin memwrite = 1'b1; dataadr = CON; writedata = $urandom; end
          5:             begin memwrite = 1'b1; dataadr = STA; writedata = $urandom; end
          6:             begin memwrite = 1'b1; dataadr = $urandom; writedata = $urandom; end
          default:       begin memwrite = 1'b0; dataadr = ($urandom_range(0, 1) == 0) ? STA : CON; end
        endcase
        memread = ($urandom_range(0, 1) == 0);
      end
      @(negedge clk); st = stall[0];
      @(posedge clk); #1;
    end
    memwrite = 1'b0; memread = 1'b0; dataadr = 32'h0;

    // Reset mid-stream with bytes queued.
    char_ready = 1'b0;
    store(STA, 32'h7);
    for (int i = 0; i < 5; i++) store(CON, 32'(8'h30 + i));
    #2 reset = 1'b0;
    #1;
    chk("t6.valid_async", 32'(char_valid[0]), 32'd0);
    chk("t6.valid_async_drop", 32'(char_valid[1]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    read_status(r0, r1);
    chk("t6.status", r0, 32'h00000001);
    chk("t6.status_drop", r1, 32'h00000001);
    chk("t6.overflow", 32'(overflow[1]), 32'd0);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
